micro_sequencer: RTL

Next-state generator for the microprogrammed control unit. Holds the 7-bit current-state register whose output addresses the microstore. Each cycle it picks the next state from the microstore's sequencing fields, the instruction decoder's encoded state, and a selectable test condition. Also provides a one-level microsubroutine return register and a stall watchdog that traps runaway memory waits.

---
 rtl/micro_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Purpose: next-state generator for the microprogrammed control unit. It owns the
//          current-state register, a one-level return register and a stall watchdog.
// Latency: one cycle; the next state is registered on the edge after the sequencing fields.
// Backpressure: none; memory waits are self-loops that release on moc or trap on timeout.
module micro_sequencer #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] TRAP_STATE     = 7'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_sel,
  input  logic [6:0] cr_addr,
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic       moc,
  input  logic       cond_in,
  input  logic [6:0] enc_state,
  output logic [6:0] state,
  output logic [6:0] ret_state,
  output logic       timeout
);

  // The counter only has to reach TIMEOUT_CYCLES-1, so this width always suffices.
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);

  // Next-state mode encodings as stored in the microstore.
  localparam logic [2:0] NS_DECODE = 3'd0;
  localparam logic [2:0] NS_FETCH  = 3'd1;
  localparam logic [2:0] NS_INC    = 3'd2;
  localparam logic [2:0] NS_JUMP   = 3'd3;
  localparam logic [2:0] NS_BR_INC = 3'd4;
  localparam logic [2:0] NS_BR_DEC = 3'd5;
  localparam logic [2:0] NS_CALL   = 3'd6;
  localparam logic [2:0] NS_RET    = 3'd7;

  localparam logic [6:0] FETCH_STATE = 7'd1;

  logic [CW-1:0] hold_cnt;
  logic          cond_raw;
  logic          cond;
  logic [6:0]    inc;
  logic [6:0]    next_state;
  logic          load_ret;
  logic          self_loop;
  logic          trap;

  // Select the test condition and apply the optional inversion.
  always_comb begin
    cond_raw = 1'b0;
    unique case (cond_sel)
      2'd0:    cond_raw = moc;
      2'd1:    cond_raw = cond_in;
      2'd2:    cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
    cond = cond_raw ^ inv;
  end

  // Compute the candidate next state; incrementing past 127 wraps to 0 naturally.
  always_comb begin
    inc        = state + 7'd1;
    next_state = inc;
    load_ret   = 1'b0;
    unique case (ns_sel)
      NS_DECODE: next_state = enc_state;
      NS_FETCH:  next_state = FETCH_STATE;
      NS_INC:    next_state = inc;
      NS_JUMP:   next_state = cr_addr;
      NS_BR_INC: next_state = cond ? cr_addr : inc;
      NS_BR_DEC: next_state = cond ? cr_addr : enc_state;
      NS_CALL: begin
        next_state = cr_addr;
        load_ret   = 1'b1;
      end
      default:   next_state = ret_state;
    endcase
  end

  // A self-loop is any cycle whose computed successor is the current state, whatever
  // mode produced it; the trap fires on the self-loop seen with the counter at its limit.
  always_comb begin
    self_loop = (next_state == state);
    trap      = self_loop && (hold_cnt == HOLD_MAX);
  end

  // Register state, return address, stall counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= 7'd0;
      ret_state <= 7'd0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else if (trap) begin
      // The trapped microinstruction is abandoned, including any return-address load.
      state    <= TRAP_STATE;
      timeout  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      if (load_ret) begin
        ret_state <= inc;
      end
      if (self_loop) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule
